// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional alignment fault checking is enabled with DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_OFF_W = 2;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read.
// Contents are never cleared by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency handshaked data-memory responder, one access in flight.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned word accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic             accept;
    logic             to_resp;
    logic [31:0]      acc_addr;
    logic             acc_we;
    logic [IDX_W-1:0] acc_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             range_err;
    logic             align_err;
    logic             acc_err;
    logic             mem_we;
    logic [31:0]      rd_data;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the response is formed on the acceptance edge,
    // so the live request is used until the latched copy exists.
    assign acc_addr  = (state == IDLE) ? req_addr : addr_q;
    assign acc_we    = (state == IDLE) ? req_we : we_q;
    assign acc_idx   = acc_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
    assign wr_idx    = addr_q[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
    assign range_err = (acc_addr >> (IDX_W + BYTE_OFF_W)) != 32'd0;

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = acc_addr[BYTE_OFF_W-1:0] != '0;
`else
    assign align_err = 1'b0;
`endif

    assign acc_err = range_err || align_err;
    assign to_resp = ((state == IDLE) && accept && (LATENCY == 1))
                  || ((state == WAIT) && (cnt == '0));

    // resp_err already carries this access's fault during RESP.
    assign mem_we = (state == RESP) && we_q && !resp_err && !rst;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_idx  (wr_idx),
        .wr_data (wdata_q),
        .rd_idx  (acc_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= to_resp;
            if (to_resp) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_we) ? 32'd0 : rd_data;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_W'(LATENCY - 2);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
